// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution / PC sequencing block.
package branch_pkg;

    // Branch condition encodings carried on ex_branch_type.
    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_type_e;

    // Controller states: RUN accepts EX outcomes, REDIRECT waits for fetch,
    // FLUSH squashes the wrong-path instructions still in IF/ID and ID/EX.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } brctl_state_e;

    // Sequential fetch increment in bytes.
    localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation from the ALU flags.
module branch_cond
    import branch_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       zero,
    input  logic       lt,
    output logic       cond
);

    // Select the flag (or its inverse) that decides this branch type.
    always_comb begin
        cond = 1'b0;
        case (br_type_e'(br_type))
            BR_EQ:   cond = zero;
            BR_NE:   cond = ~zero;
            BR_LT:   cond = lt;
            BR_GE:   cond = ~lt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and PC sequencing controller.
// Owns the fetch PC, redirects fetch on taken branches/jumps (waiting in
// REDIRECT while fetch is not ready) and holds flush_o for FLUSH_CYCLES
// cycles after the redirect so wrong-path instructions are squashed.
// Optional feature: define BRANCH_STATS_EN to build the saturating
// resolved/taken counters; otherwise br_count/taken_count read as zero.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_PC     = 32'h0000_0000,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_zero,
    input  logic            ex_lt,
    input  logic [1:0]      ex_branch_type,
    input  logic [XLEN-1:0] ex_target,
    input  logic            imem_ready,
    input  logic            stall_in,
    output logic [XLEN-1:0] pc_o,
    output logic            flush_o,
    output logic            taken_o,
    output logic [31:0]     br_count,
    output logic [31:0]     taken_count
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    brctl_state_e    state_r, state_n_s;
    logic [XLEN-1:0] pc_r, pc_n_s;
    logic [XLEN-1:0] pend_pc_r, pend_n_s;
    logic [2:0]      cnt_r, cnt_n_s;
    logic            cond_s;
    logic            squash_s;
    logic            taken_s;
    logic            accept_s;
    logic [XLEN-1:0] tgt_s;
    logic [XLEN-1:0] pc_inc_s;

    branch_cond u_cond (
        .br_type (ex_branch_type),
        .zero    (ex_zero),
        .lt      (ex_lt),
        .cond    (cond_s)
    );

    assign squash_s = (state_r != RUN);
    assign taken_s  = ex_valid & ~squash_s & (ex_jump | (ex_branch & cond_s));
    assign tgt_s    = {ex_target[XLEN-1:2], 2'b00};
    assign pc_inc_s = pc_r + XLEN'(PC_STEP);

    // Next-state, next-PC and redirect-accept decode.
    always_comb begin
        state_n_s = state_r;
        pc_n_s    = pc_r;
        pend_n_s  = pend_pc_r;
        cnt_n_s   = cnt_r;
        accept_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (taken_s) begin
                    // A taken redirect wins over stall_in: the stalled
                    // instruction is on the wrong path anyway.
                    if (imem_ready) begin
                        pc_n_s    = tgt_s;
                        accept_s  = 1'b1;
                        cnt_n_s   = FLUSH_INIT;
                        state_n_s = FLUSH;
                    end else begin
                        pend_n_s  = tgt_s;
                        state_n_s = REDIRECT;
                    end
                end else if (imem_ready && !stall_in) begin
                    pc_n_s = pc_inc_s;
                end else begin
                    pc_n_s = pc_r;
                end
            end
            REDIRECT: begin
                if (imem_ready) begin
                    pc_n_s    = pend_pc_r;
                    accept_s  = 1'b1;
                    cnt_n_s   = FLUSH_INIT;
                    state_n_s = FLUSH;
                end else begin
                    pc_n_s = pc_r;
                end
            end
            FLUSH: begin
                if (imem_ready && !stall_in) begin
                    pc_n_s = pc_inc_s;
                end else begin
                    pc_n_s = pc_r;
                end
                cnt_n_s = cnt_r - 3'd1;
                if (cnt_r <= 3'd1) begin
                    state_n_s = RUN;
                end else begin
                    state_n_s = FLUSH;
                end
            end
            default: begin
                state_n_s = RUN;
            end
        endcase
    end

    // State, PC, pending target and flush countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            pc_r      <= RESET_PC;
            pend_pc_r <= {XLEN{1'b0}};
            cnt_r     <= 3'd0;
        end else begin
            state_r   <= state_n_s;
            pc_r      <= pc_n_s;
            pend_pc_r <= pend_n_s;
            cnt_r     <= cnt_n_s;
        end
    end

    assign pc_o    = pc_r;
    assign taken_o = accept_s;
    assign flush_o = taken_s | squash_s;

`ifdef BRANCH_STATS_EN
    logic        resolve_s;
    logic [31:0] br_cnt_r;
    logic [31:0] tk_cnt_r;

    assign resolve_s = ex_valid & ~squash_s & (ex_branch | ex_jump);

    // Saturating resolved/taken statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_r <= 32'd0;
            tk_cnt_r <= 32'd0;
        end else begin
            if (resolve_s && (br_cnt_r != 32'hFFFF_FFFF)) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (taken_s && (tk_cnt_r != 32'hFFFF_FFFF)) begin
                tk_cnt_r <= tk_cnt_r + 32'd1;
            end else begin
                tk_cnt_r <= tk_cnt_r;
            end
        end
    end

    assign br_count    = br_cnt_r;
    assign taken_count = tk_cnt_r;
`else
    assign br_count    = 32'd0;
    assign taken_count = 32'd0;
`endif

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and PC sequencing controller for the pipelined core. It takes the execute-stage branch/jump outcome, evaluates the branch condition, owns the program counter, and redirects fetch when a branch is taken. It also squashes wrong-path instructions with a timed flush and holds the PC while fetch is not ready or the hazard unit stalls. It sits between the EX stage, the hazard unit and instruction memory.

## Interface
- XLEN, 32, PC/target width
- RESET_PC, 32'h0000_0000, PC value after reset
- FLUSH_CYCLES, 2, cycles flush_o stays high after redirect is issued (1..7)

- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  conditional branch in EX
- ex_jump  in  1  unconditional jump in EX (taken regardless of condition)
- ex_zero  in  1  ALU zero flag
- ex_lt  in  1  ALU result LSB (less-than result)
- ex_branch_type  in  2  00 EQ, 01 NE, 10 LT/LTU, 11 GE/GEU
- ex_target  in  XLEN  branch/jump target
- imem_ready  in  1  fetch accepts a new PC this cycle
- stall_in  in  1  hazard stall from ID
- pc_o  out  XLEN  current fetch PC
- flush_o  out  1  squash IF/ID and ID/EX contents
- taken_o  out  1  a redirect was accepted this cycle
- br_count  out  32  resolved branch/jump count
- taken_count  out  32  taken branch/jump count

## Operation
- taken = ex_valid & ~squash & (ex_jump | ex_branch & cond); cond per type: EQ zero, NE ~zero, LT lt, GE ~lt. squash = state != RUN.
- Target alignment: ex_target[1:0] forced to 2'b00 before use.
- States RUN, REDIRECT, FLUSH.
- RUN: no taken -> pc_o += 4 when imem_ready & ~stall_in, else hold. taken & imem_ready -> pc_o <= target, taken_o=1, go FLUSH, counter <= FLUSH_CYCLES. taken & ~imem_ready -> latch target into pend_pc, go REDIRECT.
- REDIRECT: hold pc_o; when imem_ready -> pc_o <= pend_pc, taken_o=1, go FLUSH, counter <= FLUSH_CYCLES. stall_in ignored.
- FLUSH: pc_o += 4 when imem_ready & ~stall_in; counter decrements every cycle; at 1 -> RUN. EX inputs ignored.
- flush_o = taken (combinational) | (state != RUN).
- Taken redirect overrides stall_in (stalled instruction is wrong-path).
- pc_o + 4 wraps modulo 2^XLEN.
- Reset (any state, incl. mid-REDIRECT): pc_o=RESET_PC, state RUN, pend_pc dropped, flush_o=0, taken_o=0, counters 0.

## Timing
- Redirect latency: taken with imem_ready at cycle t -> pc_o=target at t+1.
- Redirect with imem_ready low k cycles -> pc_o=target one cycle after imem_ready first seen high.
- flush_o high from t (detection) through the last FLUSH cycle: FLUSH_CYCLES+1 cycles for an immediate redirect.
- taken_o: single-cycle pulse, combinational, same cycle the redirect is accepted.
- pc_o, state, counters registered; cond/taken combinational.

## Configuration
- BRANCH_STATS_EN defined: br_count increments on each unsquashed ex_valid & (ex_branch | ex_jump); taken_count on each taken; both saturate at 32'hFFFF_FFFF; reset to 0.
- Undefined: counter flops omitted, br_count/taken_count tied to 0, ports kept.

## Structure
- branch_pkg: br_type_e (BR_EQ, BR_NE, BR_LT, BR_GE), brctl_state_e (RUN, REDIRECT, FLUSH), PC_STEP=4.
- Sub-module branch_cond: combinational condition evaluation (type, zero, lt -> cond).

## Test plan
- Reset release, imem_ready=1, no branches -> pc_o 0,4,8,12; flush_o=0.
- BR_EQ, zero=1, target 0x100 at cycle t -> taken_o=1 at t, pc_o=0x100 at t+1, flush_o high 3 cycles (FLUSH_CYCLES=2).
- BR_NE, zero=1 and BR_GE, lt=1 -> not taken, pc_o continues +4; BR_LT, lt=1, target 0x203 -> pc_o=0x200.
- Taken jump with imem_ready low 3 cycles -> REDIRECT, pc_o held, flush_o high; pc_o=target the cycle after imem_ready rises.
- Taken branch during FLUSH, and taken plus stall_in -> first ignored; second redirects; PC 0xFFFF_FFFC steps to 0.
- BRANCH_STATS_EN: 5 branches, 2 taken -> br_count=5, taken_count=2; rst_n low mid-REDIRECT -> pc_o=RESET_PC, counts 0.
